dmem_port_arbiter: RTL and testbench

- Shares the single-port synchronous dmem between two requesters: port 0 is the processor load/store path and port 1 is the auxiliary master (loader/debug).
- Sits between the processor's dmem outputs and the dmem syncram instance in the top level.
- Issues at most one dmem access per clock and returns read data to the owning port after the RAM read latency.
- Provides round-robin or fixed-priority arbitration, with a starvation guard in fixed-priority mode.

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_port_arbiter_rd_return_pipe.sv | 39 +++
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
// Shared constants and types for the dmem port arbiter and its neighbours.
//   DMEM_ADDR_W / DMEM_DATA_W : default dmem geometry, also used by the
//                               processor and the top level
//   PORT_PROC / PORT_AUX      : port identifiers (processor, auxiliary master)
//   rd_tag_t                  : one stage of the read return pipe
// ----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

   localparam int DMEM_ADDR_W = 12;
   localparam int DMEM_DATA_W = 32;

   localparam logic PORT_PROC = 1'b0;
   localparam logic PORT_AUX  = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rd_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_rd_return_pipe.sv
// ----------------------------------------------------------------------------
// dmem_rd_return_pipe
// RD_LAT-deep shift register of {valid, owner} tags. It tracks which port owns
// the read data that the dmem presents RD_LAT cycles after a read grant.
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous, active-high; discards every in-flight tag
//   i_tag   : tag for the access granted this cycle
//   o_tag   : tag that lines up with the current q_dmem
// ----------------------------------------------------------------------------
module dmem_rd_return_pipe
   import dmem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clock,
   input  logic    reset,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t r_stage [RD_LAT];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < RD_LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port synchronous dmem between the processor load/store
// path (port 0) and the auxiliary loader/debug master (port 1). At most one
// access is issued per clock; read data returns to the owning port RD_LAT
// cycles after its grant.
// Ports:
//   clock, reset                       : clock, async active-high reset
//   req0/we0/addr0/wdata0, gnt0        : port 0 request and accept
//   req1/we1/addr1/wdata1, gnt1        : port 1 request and accept
//   rvalid0, rvalid1, rdata            : read return, rdata shared by ports
//   address_dmem, data, wren, q_dmem   : dmem syncram interface
// ----------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DMEM_ADDR_W,
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int RD_LAT     = 1,
   parameter int FIXED_PRIO = 0,
   parameter int MAX_WAIT   = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] address_dmem,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   input  logic [DATA_W-1:0] q_dmem
);

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   logic       r_last_gnt;
   logic [7:0] r_wait_cnt;
   logic       w_gnt0;
   logic       w_gnt1;
   rd_tag_t    w_tag_in;
   rd_tag_t    w_tag_out;

   // Grant is forced off while reset is high so nothing reaches the dmem.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && !req1) begin
            w_gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            w_gnt1 = 1'b1;
         end else if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
               // port 0 wins ties until port 1 has lost MAX_WAIT cycles in a row
               if (r_wait_cnt == LP_MAX_WAIT) begin
                  w_gnt1 = 1'b1;
               end else begin
                  w_gnt0 = 1'b1;
               end
            end else begin
               if (r_last_gnt == PORT_PROC) begin
                  w_gnt1 = 1'b1;
               end else begin
                  w_gnt0 = 1'b1;
               end
            end
         end
      end
   end

   assign gnt0 = w_gnt0;
   assign gnt1 = w_gnt1;

   // Downstream drive: zero-latency mux from the granted port, idle value 0.
   always_comb begin
      address_dmem = '0;
      data         = '0;
      wren         = 1'b0;
      if (w_gnt0) begin
         address_dmem = addr0;
         data         = wdata0;
         wren         = we0;
      end else if (w_gnt1) begin
         address_dmem = addr1;
         data         = wdata1;
         wren         = we1;
      end
   end

   // Reset value of 1 makes port 0 the winner of the first round-robin tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_last_gnt <= PORT_AUX;
      end else if (w_gnt0) begin
         r_last_gnt <= PORT_PROC;
      end else if (w_gnt1) begin
         r_last_gnt <= PORT_AUX;
      end
   end

   // Consecutive cycles port 1 has been waiting; only consulted in fixed mode.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= 8'd0;
      end else if (!req1 || w_gnt1) begin
         r_wait_cnt <= 8'd0;
      end else if (r_wait_cnt < LP_MAX_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   always_comb begin
      w_tag_in       = '0;
      w_tag_in.valid = (w_gnt0 && !we0) || (w_gnt1 && !we1);
      w_tag_in.owner = w_gnt1 ? PORT_AUX : PORT_PROC;
   end

   dmem_rd_return_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_return_pipe (
      .clock (clock),
      .reset (reset),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   assign rvalid0 = w_tag_out.valid && (w_tag_out.owner == PORT_PROC);
   assign rvalid1 = w_tag_out.valid && (w_tag_out.owner == PORT_AUX);
   assign rdata   = q_dmem;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 32;

   // instance 0: round-robin, RD_LAT=1; instance 1: fixed, MAX_WAIT=3;
   // instance 2: round-robin, RD_LAT=2
   function automatic int rdl_of(int g); return (g == 2) ? 2 : 1; endfunction
   function automatic int fp_of(int g);  return (g == 1) ? 1 : 0; endfunction
   function automatic int mw_of(int g);  return (g == 1) ? 3 : 7; endfunction

   function automatic logic [31:0] mem_init(int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'h5A5A0000 | 32'(i);
   endfunction

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic          req0 [N], we0 [N], req1 [N], we1 [N];
   logic [AW-1:0] addr0 [N], addr1 [N];
   logic [DW-1:0] wdata0 [N], wdata1 [N];
   logic          gnt0 [N], gnt1 [N], rvalid0 [N], rvalid1 [N], wren [N];
   logic [AW-1:0] address_dmem [N];
   logic [DW-1:0] data [N], rdata [N], q_dmem [N];

   int checks   = 0;
   int failures = 0;

   // reference model state
   int            m_last [N];
   int            m_wait [N];
   bit            sv [N][8];
   bit            so [N][8];
   logic [DW-1:0] sd [N][8];
   logic [DW-1:0] ref_mem [N][4096];

   genvar g;
   for (g = 0; g < N; g++) begin : g_inst
      localparam int LAT = (g == 2) ? 2 : 1;
      logic [DW-1:0] mem [1<<AW];
      logic [DW-1:0] qp [LAT];
      initial for (int i = 0; i < (1<<AW); i++) mem[i] = mem_init(i);
      always @(posedge clock) begin
         if (wren[g]) mem[address_dmem[g]] <= data[g];
         qp[0] <= mem[address_dmem[g]];
         for (int k = 1; k < LAT; k++) qp[k] <= qp[k-1];
      end
      assign q_dmem[g] = qp[LAT-1];

      dmem_port_arbiter #(
         .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT),
         .FIXED_PRIO((g == 1) ? 1 : 0), .MAX_WAIT((g == 1) ? 3 : 7)
      ) u_dut (
         .clock(clock), .reset(reset),
         .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
         .gnt0(gnt0[g]), .rvalid0(rvalid0[g]),
         .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
         .gnt1(gnt1[g]), .rvalid1(rvalid1[g]),
         .rdata(rdata[g]), .address_dmem(address_dmem[g]), .data(data[g]),
         .wren(wren[g]), .q_dmem(q_dmem[g])
      );
   end

   task automatic idle_all();
      for (int i = 0; i < N; i++) begin
         req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0;
         req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_last[i] = 1;
         m_wait[i] = 0;
         for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_all();
      model_clear();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         req0[i] = 1'b1; addr0[i] = 12'h003;
         req1[i] = 1'b1; we1[i] = 1'b1; addr1[i] = 12'h004; wdata1[i] = 32'hFFFFFFFF;
      end
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (gnt0[i] !== 1'b0 || gnt1[i] !== 1'b0 || wren[i] !== 1'b0 ||
             rvalid0[i] !== 1'b0 || rvalid1[i] !== 1'b0 ||
             address_dmem[i] !== '0 || data[i] !== '0) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d got gnt=%b%b wren=%b rv=%b%b addr=%h data=%h want all zero",
                     i, gnt0[i], gnt1[i], wren[i], rvalid0[i], rvalid1[i], address_dmem[i], data[i]);
         end
      end
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) we1[i] = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (gnt0[i] !== 1'b1 || gnt1[i] !== 1'b0) begin
            failures++;
            $display("FAIL first_tie inst=%0d got gnt0=%b gnt1=%b want gnt0=1 gnt1=0", i, gnt0[i], gnt1[i]);
         end
      end
      tick();
      idle_all();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 12'h010;
      @(negedge clock);
      checks++;
      if (gnt0[0] !== 1'b1) begin
         failures++;
         $display("FAIL midrst_grant got gnt0=%b want 1", gnt0[0]);
      end
      tick();
      req0[0] = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (rvalid0[0] !== 1'b0) begin
         failures++;
         $display("FAIL midrst_rvalid_in_reset got %b want 0", rvalid0[0]);
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checks++;
         if (rvalid0[0] !== 1'b0 || rvalid1[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst_rvalid_after c=%0d got rv0=%b rv1=%b want 0 0", c, rvalid0[0], rvalid1[0]);
         end
         tick();
      end
      req0[0] = 1'b1; req1[0] = 1'b1; addr1[0] = 12'h011;
      @(negedge clock);
      checks++;
      if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0) begin
         failures++;
         $display("FAIL midrst_first_tie got gnt0=%b gnt1=%b want 1 0", gnt0[0], gnt1[0]);
      end
      tick();
      idle_all();
   endtask

   task automatic test_single_read();
      do_reset();
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 12'h010;
      @(negedge clock);
      checks++;
      if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0 || wren[0] !== 1'b0 ||
          address_dmem[0] !== 12'h010 || rvalid0[0] !== 1'b0 || rvalid1[0] !== 1'b0) begin
         failures++;
         $display("FAIL single_read_c0 got gnt=%b%b wren=%b addr=%h rv=%b%b want gnt0 addr=010",
                  gnt0[0], gnt1[0], wren[0], address_dmem[0], rvalid0[0], rvalid1[0]);
      end
      tick();
      req0[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (rvalid0[0] !== 1'b1 || rvalid1[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_read_c1 got rv0=%b rv1=%b rdata=%h want 1 0 deadbeef",
                  rvalid0[0], rvalid1[0], rdata[0]);
      end
      tick();
   endtask

   task automatic test_rr_alternate();
      logic eg0, eg1, er0, er1;
      do_reset();
      req0[0] = 1'b1; addr0[0] = 12'h010;
      req1[0] = 1'b1; addr1[0] = 12'h011;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin req0[0] = 1'b0; req1[0] = 1'b0; end
         @(negedge clock);
         eg0 = (c < 4) && (c % 2 == 0);
         eg1 = (c < 4) && (c % 2 == 1);
         er0 = (c >= 1) && ((c - 1) % 2 == 0);
         er1 = (c >= 1) && ((c - 1) % 2 == 1);
         checks++;
         if (gnt0[0] !== eg0 || gnt1[0] !== eg1) begin
            failures++;
            $display("FAIL rr_grant c=%0d got %b%b want %b%b", c, gnt0[0], gnt1[0], eg0, eg1);
         end
         checks++;
         if (rvalid0[0] !== er0 || rvalid1[0] !== er1) begin
            failures++;
            $display("FAIL rr_rvalid c=%0d got %b%b want %b%b", c, rvalid0[0], rvalid1[0], er0, er1);
         end
         if (er0 || er1) begin
            checks++;
            if (rdata[0] !== (er0 ? 32'hDEADBEEF : mem_init(17))) begin
               failures++;
               $display("FAIL rr_rdata c=%0d got %h want %h", c, rdata[0], er0 ? 32'hDEADBEEF : mem_init(17));
            end
         end
         tick();
      end
   endtask

   task automatic test_write_then_read();
      do_reset();
      req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 12'h020; wdata1[0] = 32'h12345678;
      @(negedge clock);
      checks++;
      if (gnt1[0] !== 1'b1 || wren[0] !== 1'b1 || address_dmem[0] !== 12'h020 || data[0] !== 32'h12345678) begin
         failures++;
         $display("FAIL write_drive got gnt1=%b wren=%b addr=%h data=%h want 1 1 020 12345678",
                  gnt1[0], wren[0], address_dmem[0], data[0]);
      end
      tick();
      ref_mem[0][12'h020] = 32'h12345678;
      req1[0] = 1'b0; we1[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (rvalid0[0] !== 1'b0 || rvalid1[0] !== 1'b0) begin
         failures++;
         $display("FAIL write_no_rvalid got rv0=%b rv1=%b want 0 0", rvalid0[0], rvalid1[0]);
      end
      req0[0] = 1'b1; addr0[0] = 12'h020;
      #1;
      checks++;
      if (gnt0[0] !== 1'b1 || wren[0] !== 1'b0) begin
         failures++;
         $display("FAIL wr_rd_grant got gnt0=%b wren=%b want 1 0", gnt0[0], wren[0]);
      end
      tick();
      req0[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (rvalid0[0] !== 1'b1 || rdata[0] !== 32'h12345678) begin
         failures++;
         $display("FAIL wr_rd_data got rv0=%b rdata=%h want 1 12345678", rvalid0[0], rdata[0]);
      end
      tick();
   endtask

   task automatic test_fixed_starvation();
      logic eg1;
      do_reset();
      req0[1] = 1'b1; addr0[1] = 12'h001;
      req1[1] = 1'b1; addr1[1] = 12'h002;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         eg1 = (c % 4 == 3);
         checks++;
         if (gnt0[1] !== !eg1 || gnt1[1] !== eg1) begin
            failures++;
            $display("FAIL fixed_grant c=%0d got %b%b want %b%b", c, gnt0[1], gnt1[1], !eg1, eg1);
         end
         checks++;
         if (address_dmem[1] !== (eg1 ? 12'h002 : 12'h001)) begin
            failures++;
            $display("FAIL fixed_addr c=%0d got %h want %h", c, address_dmem[1], eg1 ? 12'h002 : 12'h001);
         end
         tick();
      end
      idle_all();
   endtask

   task automatic test_rdlat2_back_to_back();
      do_reset();
      req0[2] = 1'b1; addr0[2] = 12'h010;
      @(negedge clock);
      checks++;
      if (gnt0[2] !== 1'b1 || rvalid0[2] !== 1'b0 || rvalid1[2] !== 1'b0) begin
         failures++;
         $display("FAIL lat2_c0 got gnt0=%b rv=%b%b want 1 00", gnt0[2], rvalid0[2], rvalid1[2]);
      end
      tick();
      req0[2] = 1'b0; req1[2] = 1'b1; addr1[2] = 12'h033;
      @(negedge clock);
      checks++;
      if (gnt1[2] !== 1'b1 || rvalid0[2] !== 1'b0 || rvalid1[2] !== 1'b0) begin
         failures++;
         $display("FAIL lat2_c1 got gnt1=%b rv=%b%b want 1 00", gnt1[2], rvalid0[2], rvalid1[2]);
      end
      tick();
      req1[2] = 1'b0;
      @(negedge clock);
      checks++;
      if (rvalid0[2] !== 1'b1 || rvalid1[2] !== 1'b0 || rdata[2] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL lat2_c2 got rv=%b%b rdata=%h want 10 deadbeef", rvalid0[2], rvalid1[2], rdata[2]);
      end
      tick();
      @(negedge clock);
      checks++;
      if (rvalid0[2] !== 1'b0 || rvalid1[2] !== 1'b1 || rdata[2] !== mem_init(12'h033)) begin
         failures++;
         $display("FAIL lat2_c3 got rv=%b%b rdata=%h want 01 %h", rvalid0[2], rvalid1[2], rdata[2], mem_init(12'h033));
      end
      tick();
      @(negedge clock);
      checks++;
      if (rvalid0[2] !== 1'b0 || rvalid1[2] !== 1'b0) begin
         failures++;
         $display("FAIL lat2_c4 got rv=%b%b want 00", rvalid0[2], rvalid1[2]);
      end
      tick();
   endtask

   task automatic test_random();
      int            cyc;
      int            eg [N];
      int            slot;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      do_reset();
      cyc = 0;
      for (int it = 0; it < 600; it++) begin
         if (it == 300) begin reset = 1'b1; idle_all(); model_clear(); end
         if (it == 302) reset = 1'b0;
         @(negedge clock);
         for (int i = 0; i < N; i++) begin
            eg[i] = -1;
            if (!reset) begin
               if (req0[i] && !req1[i]) eg[i] = 0;
               else if (req1[i] && !req0[i]) eg[i] = 1;
               else if (req0[i] && req1[i]) begin
                  if (fp_of(i) != 0) eg[i] = (m_wait[i] == mw_of(i)) ? 1 : 0;
                  else eg[i] = (m_last[i] == 0) ? 1 : 0;
               end
            end
            checks++;
            if (gnt0[i] !== (eg[i] == 0) || gnt1[i] !== (eg[i] == 1)) begin
               failures++;
               $display("FAIL rand_grant it=%0d inst=%0d got %b%b want port %0d", it, i, gnt0[i], gnt1[i], eg[i]);
            end
            ea = (eg[i] == 0) ? addr0[i]  : (eg[i] == 1) ? addr1[i]  : '0;
            ed = (eg[i] == 0) ? wdata0[i] : (eg[i] == 1) ? wdata1[i] : '0;
            ew = (eg[i] == 0) ? we0[i]    : (eg[i] == 1) ? we1[i]    : 1'b0;
            checks++;
            if (address_dmem[i] !== ea || data[i] !== ed || wren[i] !== ew) begin
               failures++;
               $display("FAIL rand_drive it=%0d inst=%0d got a=%h d=%h w=%b want a=%h d=%h w=%b",
                        it, i, address_dmem[i], data[i], wren[i], ea, ed, ew);
            end
            slot = cyc % 8;
            checks++;
            if (rvalid0[i] !== (sv[i][slot] && !so[i][slot]) || rvalid1[i] !== (sv[i][slot] && so[i][slot])) begin
               failures++;
               $display("FAIL rand_rvalid it=%0d inst=%0d got %b%b want valid=%b owner=%b",
                        it, i, rvalid0[i], rvalid1[i], sv[i][slot], so[i][slot]);
            end
            if (sv[i][slot]) begin
               checks++;
               if (rdata[i] !== sd[i][slot]) begin
                  failures++;
                  $display("FAIL rand_rdata it=%0d inst=%0d got %h want %h", it, i, rdata[i], sd[i][slot]);
               end
            end
            sv[i][slot] = 1'b0;
         end
         @(posedge clock);
         for (int i = 0; i < N; i++) begin
            if (eg[i] >= 0) begin
               ea = (eg[i] == 0) ? addr0[i] : addr1[i];
               ew = (eg[i] == 0) ? we0[i]   : we1[i];
               if (ew) begin
                  ref_mem[i][ea] = (eg[i] == 0) ? wdata0[i] : wdata1[i];
               end else begin
                  slot = (cyc + rdl_of(i)) % 8;
                  sv[i][slot] = 1'b1;
                  so[i][slot] = (eg[i] == 1);
                  sd[i][slot] = ref_mem[i][ea];
               end
               m_last[i] = eg[i];
            end
            if (!req1[i] || eg[i] == 1) m_wait[i] = 0;
            else if (m_wait[i] < mw_of(i)) m_wait[i]++;
         end
         cyc++;
         #1;
         for (int i = 0; i < N; i++) begin
            if (eg[i] == 0) req0[i] = 1'b0;
            if (eg[i] == 1) req1[i] = 1'b0;
            if (!reset && !req0[i] && $urandom_range(0, 2) != 0) begin
               req0[i] = 1'b1; we0[i] = ($urandom_range(0, 2) == 0);
               addr0[i] = 12'($urandom_range(0, 31)); wdata0[i] = $urandom;
            end
            if (!reset && !req1[i] && $urandom_range(0, 2) != 0) begin
               req1[i] = 1'b1; we1[i] = ($urandom_range(0, 2) == 0);
               addr1[i] = 12'($urandom_range(0, 31)); wdata1[i] = $urandom;
            end
         end
      end
      idle_all();
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      model_clear();
      for (int i = 0; i < N; i++)
         for (int a = 0; a < 4096; a++) ref_mem[i][a] = mem_init(a);
      test_reset();
      test_reset_mid_read();
      test_single_read();
      test_rr_alternate();
      test_write_then_read();
      test_fixed_starvation();
      test_rdlat2_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
